// File: rtl/sal_axi_traffic_gen.sv
// Self-checking AXI4 master: writes a 2-beat INCR burst per transaction, reads it back,
// and reports data/response mismatches, handshake timeouts and the first failing address.
module sal_axi_traffic_gen #(
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 128,
    parameter int NUM_TXN     = 16,
    parameter int ADDR_STRIDE = 32,
    parameter int INIT_WAIT   = 250,
    parameter int TIMEOUT     = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [31:0]             seed,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             err_cnt,
    output logic                    timeout,
    output logic [ADDR_WIDTH-1:0]   first_err_addr,
    output logic [8:0]              txn_cnt
);
    localparam int         WORDS  = DATA_WIDTH / 32;
    localparam logic [2:0] AXSIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam int         INIT_W = $clog2(INIT_WAIT + 1);
    localparam int         TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_WR, S_WB, S_RA, S_RD, S_DONE} state_t;

    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [31:0] s,
                                                        input logic [8:0]  i,
                                                        input logic        k);
        logic [31:0] w;
        w = s + {22'd0, i, 1'b0} + {31'd0, k};
        return {WORDS{w}};
    endfunction

    state_t                  state_q, state_d;
    logic [8:0]              idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             seed_q, seed_d;
    logic [INIT_W-1:0]       init_cnt_q, init_cnt_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                    w_beat_q, w_beat_d, r_beat_q, r_beat_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic                    busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                    timeout_q, timeout_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0]   first_err_q, first_err_d;
    logic [8:0]              txn_cnt_q, txn_cnt_d;
    logic [ID_WIDTH-1:0]     cur_id;
    logic                    err_inc, finish, hs;

    assign cur_id = ID_WIDTH'(idx_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        seed_d      = seed_q;
        init_cnt_d  = init_cnt_q;
        to_cnt_d    = to_cnt_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        w_beat_d    = w_beat_q;
        r_beat_d    = r_beat_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        wlast_d     = wlast_q;
        wdata_d     = wdata_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        txn_cnt_d   = txn_cnt_q;
        err_inc     = 1'b0;
        finish      = 1'b0;
        hs = (awvalid_q && awready) || (wvalid_q && wready) || (bready_q && bvalid) ||
             (arvalid_q && arready) || (rready_q && rvalid);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    seed_d     = seed;
                    addr_d     = base_addr;
                    idx_d      = '0;
                    init_cnt_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_cnt_d  = '0;
                    timeout_d  = 1'b0;
                    txn_cnt_d  = '0;
                    state_d    = S_INIT;
                end
            end
            S_INIT: begin
                if (init_cnt_q == INIT_W'(INIT_WAIT - 1)) begin
                    state_d   = S_WR;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    wlast_d   = 1'b0;
                    wdata_d   = beat_data(seed_q, idx_q, 1'b0);
                    w_beat_d  = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    to_cnt_d  = '0;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            S_WR: begin
                // AW and W handshake independently; leave only when both are finished.
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && wready) begin
                    if (!w_beat_q) begin
                        w_beat_d = 1'b1;
                        wlast_d  = 1'b1;
                        wdata_d  = beat_data(seed_q, idx_q, 1'b1);
                    end else begin
                        wvalid_d = 1'b0;
                        wlast_d  = 1'b0;
                        w_done_d = 1'b1;
                    end
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = S_WB;
                    bready_d = 1'b1;
                end
            end
            S_WB: begin
                if (bvalid) begin
                    err_inc   = (bid != cur_id) || (bresp != 2'b00);
                    bready_d  = 1'b0;
                    arvalid_d = 1'b1;
                    state_d   = S_RA;
                end
            end
            S_RA: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    r_beat_d  = 1'b0;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                if (rvalid) begin
                    err_inc = (rid != cur_id) || (rresp != 2'b00) || (rlast != r_beat_q) ||
                              (rdata != beat_data(seed_q, idx_q, r_beat_q));
                    if (!r_beat_q) begin
                        r_beat_d = 1'b1;
                    end else begin
                        rready_d  = 1'b0;
                        txn_cnt_d = txn_cnt_q + 9'd1;
                        if (idx_q == 9'(NUM_TXN - 1)) begin
                            finish  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            idx_d     = idx_q + 9'd1;
                            addr_d    = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
                            state_d   = S_WR;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                            wlast_d   = 1'b0;
                            wdata_d   = beat_data(seed_q, idx_q + 9'd1, 1'b0);
                            w_beat_d  = 1'b0;
                            aw_done_d = 1'b0;
                            w_done_d  = 1'b0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (err_inc) begin
            if (err_cnt_q == 16'd0) first_err_d = addr_q;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end

        if (finish) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_cnt_d == 16'd0) && !timeout_q;
        end

        // One watchdog covers every handshake wait; any handshake restarts it.
        if (state_q inside {S_WR, S_WB, S_RA, S_RD}) begin
            if (hs) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                timeout_d = 1'b1;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                wlast_d   = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                pass_d    = 1'b0;
                state_d   = S_DONE;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            seed_q      <= '0;
            init_cnt_q  <= '0;
            to_cnt_q    <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            w_beat_q    <= 1'b0;
            r_beat_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            wdata_q     <= '0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            txn_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            seed_q      <= seed_d;
            init_cnt_q  <= init_cnt_d;
            to_cnt_q    <= to_cnt_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            w_beat_q    <= w_beat_d;
            r_beat_q    <= r_beat_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            wlast_q     <= wlast_d;
            wdata_q     <= wdata_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            txn_cnt_q   <= txn_cnt_d;
        end
    end

    assign awid           = cur_id;
    assign awaddr         = addr_q;
    assign awlen          = 8'd1;
    assign awsize         = AXSIZE;
    assign awburst        = 2'b01;
    assign awvalid        = awvalid_q;
    assign wdata          = wdata_q;
    assign wstrb          = '1;
    assign wlast          = wlast_q;
    assign wvalid         = wvalid_q;
    assign bready         = bready_q;
    assign arid           = cur_id;
    assign araddr         = addr_q;
    assign arlen          = 8'd1;
    assign arsize         = AXSIZE;
    assign arburst        = 2'b01;
    assign arvalid        = arvalid_q;
    assign rready         = rready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign timeout        = timeout_q;
    assign first_err_addr = first_err_q;
    assign txn_cnt        = txn_cnt_q;
endmodule

// File: tb/tb_sal_axi_traffic_gen.sv
// Testbench for sal_axi_traffic_gen: a behavioural AXI slave with fault injection and
// randomized ready, checked against expected addresses/data computed from the run inputs.
module tb_sal_axi_traffic_gen;
    localparam int NTXN   = 4;
    localparam int STRIDE = 32;
    localparam int TMO    = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, start = 1'b0;
    logic [31:0]  base_addr = '0, seed = '0;
    logic [3:0]   awid, arid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst;
    logic         awvalid, wvalid, wlast, bready, arvalid, rready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0;
    logic         rvalid = 1'b0, rlast = 1'b0;
    logic [3:0]   bid = '0, rid = '0;
    logic [1:0]   bresp = '0, rresp = '0;
    logic [127:0] rdata = '0;
    logic         busy, done, pass, timeout;
    logic [15:0]  err_cnt;
    logic [31:0]  first_err_addr;
    logic [8:0]   txn_cnt;

    sal_axi_traffic_gen #(
        .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(128), .NUM_TXN(NTXN),
        .ADDR_STRIDE(STRIDE), .INIT_WAIT(20), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .seed(seed),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .timeout(timeout),
        .first_err_addr(first_err_addr), .txn_cnt(txn_cnt)
    );

    int checks_total = 0;
    int checks_passed = 0;

    // Slave behaviour knobs, written only by the main sequence.
    int          aw_stall = 0;
    bit          rand_ready = 1'b0, no_arready = 1'b0, slave_clear = 1'b0;
    int          bad_rdata_txn = -1, bad_bresp_txn = -1, bad_rlast_txn = -1;
    logic [31:0] cur_base = '0, cur_seed = '0;

    // Slave internal state, written only by the slave process.
    bit           aw_got = 1'b0, b_hs = 1'b0, ar_hs = 1'b0, r_hs = 1'b0, r_active = 1'b0;
    int           aw_wait_cnt = 0, w_beats = 0, wr_txn = 0, rd_txn = 0, r_beat = 0;
    logic [31:0]  got_awaddr = '0, got_araddr = '0;
    logic [3:0]   got_awid = '0, got_arid = '0;
    logic [127:0] wbuf [2];
    logic [127:0] mem [logic [31:0]];
    logic [31:0]  w_log [NTXN][2];

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    // Reference model: addresses and beat data follow directly from base, seed and index.
    function automatic logic [31:0] model_addr(input int i);
        return cur_base + 32'(i * STRIDE);
    endfunction

    function automatic logic [127:0] model_data(input int i, input int k);
        logic [31:0] w;
        w = cur_seed + 32'(2 * i + k);
        return {w, w, w, w};
    endfunction

    // Behavioural slave: decides its outputs on the falling edge for the next rising edge,
    // so every handshake it records here is the one the DUT sees on that rising edge.
    always @(negedge clk) begin
        if (rst || slave_clear) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
            bid = '0; bresp = '0; rid = '0; rresp = '0; rdata = '0;
            aw_got = 0; aw_wait_cnt = 0; w_beats = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            r_active = 0; r_beat = 0; wr_txn = 0; rd_txn = 0;
        end else begin
            awready = 1'b0;
            if (awvalid && !aw_got) begin
                checkOutput("awaddr", awaddr, model_addr(wr_txn));
                if (aw_wait_cnt >= aw_stall && (!rand_ready || $urandom_range(0, 1) == 1)) begin
                    awready = 1'b1; aw_got = 1'b1; got_awid = awid; got_awaddr = awaddr;
                    checkOutput("awid", awid, 4'(wr_txn));
                    checkOutput("aw_len_size_burst", {awlen, awsize, awburst}, {8'd1, 3'd4, 2'b01});
                    if (aw_stall > 0) checkOutput("w_before_aw", w_beats, 2);
                end
                aw_wait_cnt++;
            end

            wready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (wvalid && wready && w_beats < 2) begin
                checkOutput("wdata", wdata, model_data(wr_txn, w_beats));
                checkOutput("wlast", wlast, w_beats == 1);
                checkOutput("wstrb", wstrb, 16'hFFFF);
                wbuf[w_beats] = wdata;
                if (wr_txn < NTXN) w_log[wr_txn][w_beats] = wdata[31:0];
                w_beats++;
            end

            if (b_hs) begin
                bvalid = 0; b_hs = 0; aw_got = 0; aw_wait_cnt = 0; w_beats = 0; wr_txn++;
            end
            if (!bvalid && aw_got && w_beats == 2) begin
                mem[got_awaddr] = wbuf[0];
                mem[got_awaddr + 32'd16] = wbuf[1];
                bvalid = 1'b1; bid = got_awid;
                bresp = (wr_txn == bad_bresp_txn) ? 2'b10 : 2'b00;
            end
            if (bvalid && bready) b_hs = 1'b1;

            if (r_hs) begin
                r_hs = 0; rvalid = 0; r_beat++;
                if (r_beat == 2) begin r_active = 0; rd_txn++; end
            end
            if (ar_hs) begin ar_hs = 0; r_active = 1'b1; r_beat = 0; end
            arready = !no_arready && !r_active && (!rand_ready || $urandom_range(0, 1) == 1);
            if (arvalid && arready) begin
                checkOutput("araddr", araddr, model_addr(rd_txn));
                checkOutput("arid", arid, 4'(rd_txn));
                checkOutput("ar_len_size_burst", {arlen, arsize, arburst}, {8'd1, 3'd4, 2'b01});
                ar_hs = 1'b1; got_araddr = araddr; got_arid = arid;
            end

            if (r_active && !rvalid && (!rand_ready || $urandom_range(0, 1) == 1)) begin
                rvalid = 1'b1; rid = got_arid; rresp = 2'b00;
                rdata = mem.exists(got_araddr + 32'(16 * r_beat)) ? mem[got_araddr + 32'(16 * r_beat)] : '0;
                if (rd_txn == bad_rdata_txn && r_beat == 1) rdata[0] = ~rdata[0];
                rlast = (r_beat == 1) || (rd_txn == bad_rlast_txn);
            end
            if (rvalid && rready) r_hs = 1'b1;
        end
    end

    task automatic prepSlave(input int stall, input bit rr, input bit noar,
                             input int brd, input int bbr, input int brl);
        aw_stall = stall; rand_ready = rr; no_arready = noar;
        bad_rdata_txn = brd; bad_bresp_txn = bbr; bad_rlast_txn = brl;
        slave_clear = 1'b1;
        @(negedge clk); #1;
        slave_clear = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] b, input logic [31:0] s);
        @(posedge clk); #1;
        cur_base = b; cur_seed = s;
        base_addr = b; seed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("done_reached", done, 1'b1);
    endtask

    task automatic checkRun(input int exp_err, input logic [31:0] exp_first,
                            input bit exp_to, input int exp_txn);
        checkOutput("busy_at_done", busy, 1'b0);
        checkOutput("pass", pass, (exp_err == 0) && !exp_to);
        checkOutput("err_cnt", err_cnt, 16'(exp_err));
        checkOutput("timeout", timeout, exp_to);
        checkOutput("txn_cnt", txn_cnt, 9'(exp_txn));
        if (exp_err > 0) checkOutput("first_err_addr", first_err_addr, exp_first);
    endtask

    initial begin
        logic [31:0] b, s;
        int n;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valids_readys", {awvalid, wvalid, bready, arvalid, rready}, 5'd0);
        checkOutput("rst_status", {busy, done, pass, timeout}, 4'd0);
        checkOutput("rst_counts", {err_cnt, txn_cnt, first_err_addr}, '0);
        rst = 1'b0;

        $display("[TB] ideal slave, base 0, seed 01234567");
        prepSlave(0, 0, 0, -1, -1, -1);
        applyStimulus(32'h0, 32'h01234567);
        checkOutput("busy_after_start", busy, 1'b1);
        waitDone(3000);
        checkRun(0, '0, 0, NTXN);
        checkOutput("txn2_beat1_word", w_log[2][1], 32'h0123456C);

        $display("[TB] awready stalled, stray start while busy");
        prepSlave(5, 0, 0, -1, -1, -1);
        b = $urandom; s = $urandom;
        applyStimulus(b, s);
        repeat (40) @(posedge clk);
        #1;
        base_addr = ~b; seed = ~s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(3000);
        checkRun(0, '0, 0, NTXN);

        $display("[TB] random readies, corrupt read beat 1 of txn 1");
        prepSlave(0, 1, 0, 1, -1, -1);
        b = $urandom; s = $urandom;
        applyStimulus(b, s);
        waitDone(5000);
        checkRun(1, b + 32'h20, 0, NTXN);

        $display("[TB] random readies, bad bresp on txn 0 and early rlast on txn 3");
        prepSlave(0, 1, 0, -1, 0, 3);
        b = $urandom; s = $urandom;
        applyStimulus(b, s);
        waitDone(5000);
        checkRun(2, b, 0, NTXN);

        $display("[TB] arready never asserted");
        prepSlave(0, 0, 1, -1, -1, -1);
        applyStimulus($urandom, $urandom);
        n = 0;
        while (arvalid !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("arvalid_rise", arvalid, 1'b1);
        n = 0;
        while (timeout !== 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("timeout_latency", n, TMO);
        checkOutput("arvalid_dropped", arvalid, 1'b0);
        checkOutput("done_on_timeout", done, 1'b1);
        checkRun(0, '0, 1, 0);

        $display("[TB] reset during read of txn 2, then clean rerun");
        prepSlave(0, 0, 0, -1, -1, -1);
        applyStimulus($urandom, $urandom);
        n = 0;
        while (!(rready === 1'b1 && rd_txn == 2) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("reached_txn2_read", rready, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrun_rst_valids_readys", {awvalid, wvalid, bready, arvalid, rready}, 5'd0);
        checkOutput("midrun_rst_busy", busy, 1'b0);
        rst = 1'b0;
        prepSlave(0, 0, 0, -1, -1, -1);
        applyStimulus($urandom, $urandom);
        waitDone(3000);
        checkRun(0, '0, 0, NTXN);

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/sal_axi_traffic_gen.md
Name: sal_axi_traffic_gen

Overview:
- Self-checking AXI4 master that sits directly upstream of SAL_DDR_CTRL's AXI slave ports (AW/W/B/AR/R) in place of the hand-written stimulus.
- For each of NUM_TXN transactions: writes a 2-beat INCR burst, waits for B, reads the same address back, and compares.
- Reports pass/fail, error count and first failing address for regression and bring-up.

Parameters:
- ID_WIDTH, 4, AXI ID width
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 128, AXI data width; multiple of 32
- NUM_TXN, 16, write/read pairs per run; 1..256
- ADDR_STRIDE, 32, byte increment between transactions
- INIT_WAIT, 250, idle cycles after start, for DRAM init
- TIMEOUT, 1024, max cycles waiting on any single handshake

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; ignored unless in IDLE or DONE
- base_addr  in  ADDR_WIDTH  first transaction address; sampled on start
- seed  in  32  data pattern seed; sampled on start
- awid/awaddr/awlen/awsize/awburst/awvalid  out  ID/ADDR/8/3/2/1  write address channel
- awready  in  1
- wdata/wstrb/wlast/wvalid  out  DATA/DATA/8/1/1  write data channel
- wready  in  1
- bid/bresp/bvalid  in  ID/2/1;  bready  out  1
- arid/araddr/arlen/arsize/arburst/arvalid  out  same widths as AW channel
- arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  ID/DATA/2/1/1;  rready  out  1
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- pass  out  1  valid when done: err_cnt==0 and no timeout
- err_cnt  out  16  saturating mismatch/response error count
- timeout  out  1  sticky; a handshake exceeded TIMEOUT
- first_err_addr  out  ADDR_WIDTH  address of first erroring transaction
- txn_cnt  out  9  completed write/read pairs

Behaviour:
- Reset:
  - All valid/ready outputs are 0.
  - busy, done, pass, timeout, err_cnt, txn_cnt and first_err_addr are 0.
  - FSM goes to IDLE.
  - A reset mid-run aborts immediately; no AXI completion is required.
- Transaction i (0-based):
  - addr = base_addr + i*ADDR_STRIDE, computed modulo 2^ADDR_WIDTH.
  - ID = i[ID_WIDTH-1:0].
  - awlen/arlen = 1, awsize/arsize = log2(DATA_WIDTH/8), burst = 2'b01 (INCR).
  - Beat k (0 or 1) data = 32-bit word (seed + 2*i + k), replicated DATA_WIDTH/32 times.
  - wstrb is all ones.
- FSM states:
  - IDLE: on start, latch inputs, set busy, clear err_cnt/timeout/txn_cnt/done, go to INIT.
  - INIT: count INIT_WAIT cycles, then go to WR.
  - WR:
    - Assert awvalid and wvalid in the same cycle; the two channels handshake independently.
    - AW drops after its awready cycle.
    - W presents beat 0, then beat 1 with wlast=1; the beat advances on wvalid&wready.
    - Go to WB once both AW and the last W beat have completed.
  - WB:
    - bready=1. On bvalid, error if bid != ID or bresp != 0. Go to RA.
  - RA:
    - arvalid=1 until arready, then go to RD.
  - RD:
    - rready=1. Each beat is checked for rid == ID, rresp == 0, data == expected.
    - rlast must be 0 on beat 0 and 1 on beat 1.
    - After beat 1: increment txn_cnt; if i == NUM_TXN-1 go to DONE, else i++ and go to WR.
  - DONE:
    - busy=0, done=1, pass = (err_cnt==0 && !timeout).
    - start re-runs the sequence.
- Error counting:
  - Each failing check adds 1 to err_cnt, at most 1 per beat or response; saturates at 16'hFFFF.
  - first_err_addr is captured only when err_cnt goes 0→1.
- AXI rules:
  - valid is never deasserted before its handshake.
  - Payload is stable while valid is high.
  - valid does not depend combinationally on ready.
  - All outputs are registered.
- Timeout:
  - One counter runs in WR/WB/RA/RD; it resets on every handshake.
  - On reaching TIMEOUT: set timeout, drop all valids/readys, go to DONE (pass=0).
- start while busy: ignored.
- start in the same cycle as rst: rst wins.

Test Plan:
- Ideal slave model (ready always 1, correct echo), NUM_TXN=4, base=0, seed=32'h01234567 → awaddr 0,0x20,0x40,0x60; beat-1 word of txn 2 = 32'h0123456C; done=1, pass=1, err_cnt=0, txn_cnt=4.
- Slave holds awready low 5 cycles while wready=1 → both W beats complete first, AW completes later, awaddr stable throughout, single B accepted, pass=1.
- Slave corrupts rdata beat 1 of txn 1 → err_cnt=1, first_err_addr=0x20, pass=0, run still completes txn_cnt=4.
- Slave returns bresp=2'b10 on txn 0 and rlast=1 on beat 0 of txn 3 → err_cnt=2, first_err_addr=base.
- Slave never asserts arready, TIMEOUT=1024 → timeout=1 exactly 1024 cycles after arvalid rises, arvalid drops, done=1, pass=0.
- Assert rst during RD of txn 2 → next cycle all valids/readys 0, busy=0; a subsequent start runs cleanly with pass=1.
